comm_master: RTL and testbench

// - Bench/host-side command master for the quadcopter wireless link (UART, 8N1).
// - On a send_cmd pulse, serialises a 3-byte frame to the copter: cmd, data[15:8], data[7:0].
// - Receives the copter's 1-byte response (e.g. 0xA5 positive ack) and flags it with resp_rdy.
// - Sits between the test stimulus and the copter's UART: TX drives copter RX, RX listens to copter TX.

---
 rtl/comm_pkg.sv | 11 +
 rtl/uart_trx.sv | 166 ++++++++++++++++
 rtl/comm_master.sv | 95 +++++++++
 tb/tb_comm_master.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the host-side copter command link.
// Holds the frame FSM encoding, the receiver's state encoding and the default bit period.
package comm_pkg;

  typedef enum logic [1:0] {IDLE, BYTE_H, BYTE_M, BYTE_L} frame_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [7:0] POS_ACK       = 8'hA5;
  localparam int         BAUD_DIV_DFLT = 2604;

endpackage

// File: rtl/uart_trx.sv
// 8N1 UART: TX shifter reloadable on the tx_done cycle for gapless bytes; RX samples mid-bit after a 2-flop sync.
// tx_done is combinational at the end of the stop bit; rx_rdy is sticky until clr_rx_rdy or a validated start.
module uart_trx
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam logic [15:0] BD_LAST   = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [15:0] tx_baud_q, tx_baud_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        tx_busy_q, tx_busy_d;
  logic        tx_baud_end;

  assign tx_baud_end = tx_busy_q && (tx_baud_q == BD_LAST);
  assign tx_done     = tx_baud_end && (tx_bit_q == 4'd9);
  // Ones shift in behind the frame, so the line rests high without a mux.
  assign TX          = tx_shift_q[0];

  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_busy_d  = tx_busy_q;
    if (tx_busy_q) begin
      if (tx_baud_end) begin
        tx_baud_d  = 16'd0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
        if (tx_done) tx_busy_d = 1'b0;
      end else begin
        tx_baud_d = tx_baud_q + 16'd1;
      end
    end
    if (trmt) begin
      tx_shift_d = {1'b1, tx_data, 1'b0};
      tx_baud_d  = 16'd0;
      tx_bit_d   = 4'd0;
      tx_busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '1;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  rx_state_t   rx_state_q, rx_state_d;
  logic        rx_sync1_q, rx_sync2_q, rx_sync3_q;
  logic [15:0] rx_baud_q, rx_baud_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_rdy_q, rx_rdy_d;
  logic        rx_fall, start_ok, byte_ok;

  // sync3 only remembers the previous synchronised level for edge detection.
  assign rx_fall = rx_sync3_q && !rx_sync2_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    start_ok   = 1'b0;
    byte_ok    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_baud_d  = 16'd0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d = 16'd0;
          if (!rx_sync2_q) begin
            start_ok   = 1'b1;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BD_LAST) begin
          rx_baud_d  = 16'd0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      default: begin
        if (rx_baud_q == BD_LAST) begin
          rx_baud_d  = 16'd0;
          rx_state_d = RX_IDLE;
          if (rx_sync2_q) begin
            rx_data_d = rx_shift_q;
            byte_ok   = 1'b1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
    endcase
    rx_rdy_d = rx_rdy_q;
    if (clr_rx_rdy || start_ok) rx_rdy_d = 1'b0;
    if (byte_ok) rx_rdy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_sync3_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      rx_sync1_q <= RX;
      rx_sync2_q <= rx_sync1_q;
      rx_sync3_q <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_rdy_q   <= rx_rdy_d;
    end
  end

endmodule

// File: rtl/comm_master.sv
// Host command master: sends {cmd, data_hi, data_lo} over UART; frame takes 30*BAUD_DIV clocks.
// No backpressure: send_cmd outside IDLE is dropped; responses are flagged by the sticky resp_rdy.
module comm_master
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        send_cmd,
  output logic        frm_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  frame_state_t state_q, state_d;
  logic [23:0]  hold_q, hold_d;
  logic         frm_snt_q, frm_snt_d;
  logic         trmt, tx_done, clr_rx_rdy;
  logic [7:0]   tx_data;

  // Next byte is loaded on the tx_done cycle, so bytes run back-to-back.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    frm_snt_d  = frm_snt_q;
    trmt       = 1'b0;
    tx_data    = hold_q[23:16];
    clr_rx_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_cmd) begin
          hold_d     = {cmd, data};
          frm_snt_d  = 1'b0;
          trmt       = 1'b1;
          tx_data    = cmd;
          clr_rx_rdy = 1'b1;
          state_d    = BYTE_H;
        end
      end
      BYTE_H: begin
        tx_data = hold_q[15:8];
        if (tx_done) begin
          trmt    = 1'b1;
          state_d = BYTE_M;
        end
      end
      BYTE_M: begin
        tx_data = hold_q[7:0];
        if (tx_done) begin
          trmt    = 1'b1;
          state_d = BYTE_L;
        end
      end
      default: begin
        if (tx_done) begin
          frm_snt_d = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      frm_snt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      frm_snt_q <= frm_snt_d;
    end
  end

  assign frm_snt = frm_snt_q;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk        (clk),
    .rst_n      (rst_n),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .TX         (TX),
    .RX         (RX),
    .clr_rx_rdy (clr_rx_rdy),
    .rx_rdy     (resp_rdy),
    .rx_data    (resp)
  );

endmodule

// File: tb/tb_comm_master.sv
// Directed bench for comm_master at BAUD_DIV=16: TX line decoding, response capture, glitch, overlap, reset.
module tb_comm_master;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        send_cmd = 1'b0;
  logic        frm_snt, resp_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int failures = 0;

  comm_master #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .send_cmd(send_cmd), .frm_snt(frm_snt), .resp_rdy(resp_rdy), .resp(resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  e0, e1, e2;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_rise(input string name, input int rise);
    checks++;
    if (rise < 30*BD - 2 || rise > 30*BD + 2) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d+/-2", name, rise, 30*BD);
    end
  endtask

  // Line image of a frame, index 0 = first start bit.
  function automatic logic [29:0] line_bits(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    return {1'b1, b2, 1'b0, 1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
  endfunction

  task automatic run_frame(input logic [7:0] c, input logic [15:0] d, output logic [29:0] bits,
                           output int rise, output logic rdy0, output logic snt0);
    int t;
    @(negedge clk);
    cmd = c; data = d; send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    rdy0 = resp_rdy;
    snt0 = frm_snt;
    bits = '0;
    rise = -1;
    t = 0;
    while (rise < 0 && t <= 600) begin
      if (t < 30*BD && (t % BD) == BD/2) bits[t/BD] = TX;
      if (frm_snt) rise = t;
      t++;
      @(negedge clk);
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic watch_idle(input string name, input int n);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
    end
    chk(name, lows, 0);
  endtask

  logic [29:0] bits;
  int          rise;
  logic        rdy0, snt0;

  initial begin
    tbl[0] = '{cmd: 8'h05, data: 16'h01FF, e0: 8'h05, e1: 8'h01, e2: 8'hFF};
    tbl[1] = '{cmd: 8'h06, data: 16'hFFFF, e0: 8'h06, e1: 8'hFF, e2: 8'hFF};
    tbl[2] = '{cmd: 8'h06, data: 16'h0000, e0: 8'h06, e1: 8'h00, e2: 8'h00};
    tbl[3] = '{cmd: 8'hA5, data: 16'h5A3C, e0: 8'hA5, e1: 8'h5A, e2: 8'h3C};

    #23;
    chk("rst_tx", TX, 1'b1);
    chk("rst_frm_snt", frm_snt, 1'b0);
    chk("rst_resp_rdy", resp_rdy, 1'b0);
    chk("rst_resp", resp, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].cmd, tbl[i].data, bits, rise, rdy0, snt0);
      chk($sformatf("frame%0d_bits", i), bits, line_bits(tbl[i].e0, tbl[i].e1, tbl[i].e2));
      chk_rise($sformatf("frame%0d_rise", i), rise);
      chk($sformatf("frame%0d_snt_clr", i), snt0, 1'b0);
      watch_idle($sformatf("frame%0d_idle", i), 40);
      chk($sformatf("frame%0d_snt_sticky", i), frm_snt, 1'b1);
    end

    // 3-clock low pulse must die at the half-bit recheck.
    @(negedge clk);
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rdy", resp_rdy, 1'b0);

    drive_rx(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    chk("frame_err_rdy", resp_rdy, 1'b0);
    chk("frame_err_resp", resp, 8'h00);

    drive_rx(8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    chk("ack_rdy", resp_rdy, 1'b1);
    chk("ack_resp", resp, 8'hA5);
    repeat (100) @(negedge clk);
    chk("ack_rdy_sticky", resp_rdy, 1'b1);

    // Second command mid-frame is ignored; a response arriving mid-frame is still captured.
    fork
      run_frame(8'h05, 16'h01FF, bits, rise, rdy0, snt0);
      begin
        repeat (100) @(negedge clk);
        cmd = 8'h04; data = 16'h00FF; send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
      end
      begin
        repeat (200) @(negedge clk);
        drive_rx(8'h5A, 1'b1);
      end
    join
    chk("ovl_rdy_cleared", rdy0, 1'b0);
    chk("ovl_bits", bits, line_bits(8'h05, 8'h01, 8'hFF));
    chk_rise("ovl_rise", rise);
    chk("ovl_resp_rdy", resp_rdy, 1'b1);
    chk("ovl_resp", resp, 8'h5A);
    watch_idle("ovl_no_second_frame", 40);

    // Reset while byte 2 data bit 2 (a zero) is on the line.
    fork
      begin
        @(negedge clk);
        cmd = 8'h05; data = 16'h01FF; send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        repeat (13*BD + 4) @(negedge clk);
      end
      begin
        repeat (10) @(negedge clk);
        drive_rx(8'hA5, 1'b1);
      end
    join
    chk("pre_rst_tx_low", TX, 1'b0);
    chk("pre_rst_rdy", resp_rdy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", TX, 1'b1);
    chk("mid_rst_frm_snt", frm_snt, 1'b0);
    chk("mid_rst_rdy", resp_rdy, 1'b0);
    chk("mid_rst_resp", resp, 8'h00);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    watch_idle("post_rst_idle", 20);
    run_frame(8'h05, 16'h01FF, bits, rise, rdy0, snt0);
    chk("post_rst_bits", bits, line_bits(8'h05, 8'h01, 8'hFF));
    chk_rise("post_rst_rise", rise);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
